// File: rtl/display_scan_ctrl.sv
// display_scan_ctrl: converts a saturated 10-bit distance value to three BCD
// digits by sequential double-dabble, then time-multiplexes the digits onto
// the 7-segment decoder's mostrar/digito inputs at a DIV-cycle dwell per digit.
module display_scan_ctrl #(
    parameter int DIV = 50000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [9:0] value,
    input  logic       load,
    output logic       busy,
    output logic       done,
    output logic [1:0] mostrar,
    output logic [3:0] digito
);

    localparam int PW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(DIV - 1);

    typedef enum logic {
        IDLE,
        CONV
    } state_t;

    state_t        state_q, state_d;
    logic [21:0]   sr_q, sr_d;       // {hundreds, tens, units, binary}
    logic [3:0]    it_q, it_d;       // shift iteration 0..9
    logic [3:0]    hun_q, hun_d;
    logic [3:0]    ten_q, ten_d;
    logic [3:0]    uni_q, uni_d;
    logic          done_q, done_d;
    logic [PW-1:0] presc_q, presc_d;
    logic [1:0]    mostrar_q, mostrar_d;
    logic [21:0]   step;

    // Nibble correction before a shift; 4-bit result, never exceeds 12.
    function automatic logic [3:0] add3(input logic [3:0] n);
        return (n >= 4'd5) ? n + 4'd3 : n;
    endfunction

    // One double-dabble iteration: correct all BCD nibbles, then shift left.
    function automatic logic [21:0] dabble_step(input logic [21:0] s);
        return {add3(s[21:18]), add3(s[17:14]), add3(s[13:10]), s[9:0]} << 1;
    endfunction

    // Values above the 3-digit range are clamped to 999.
    function automatic logic [9:0] saturate(input logic [9:0] v);
        return (v > 10'd999) ? 10'd999 : v;
    endfunction

    assign step = dabble_step(sr_q);

    // Register all state; reset clears conversion, display and scan alike.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            sr_q      <= '0;
            it_q      <= '0;
            hun_q     <= '0;
            ten_q     <= '0;
            uni_q     <= '0;
            done_q    <= 1'b0;
            presc_q   <= '0;
            mostrar_q <= 2'b01;
        end else begin
            state_q   <= state_d;
            sr_q      <= sr_d;
            it_q      <= it_d;
            hun_q     <= hun_d;
            ten_q     <= ten_d;
            uni_q     <= uni_d;
            done_q    <= done_d;
            presc_q   <= presc_d;
            mostrar_q <= mostrar_d;
        end
    end

    // Conversion FSM: capture on load in IDLE, ten shifts in CONV, then publish.
    always_comb begin
        state_d = state_q;
        sr_d    = sr_q;
        it_d    = it_q;
        hun_d   = hun_q;
        ten_d   = ten_q;
        uni_d   = uni_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (load) begin
                    state_d = CONV;
                    sr_d    = {12'd0, saturate(value)};
                    it_d    = 4'd0;
                end
            end
            CONV: begin
                sr_d = step;
                if (it_q == 4'd9) begin
                    state_d = IDLE;
                    it_d    = 4'd0;
                    hun_d   = step[21:18];
                    ten_d   = step[17:14];
                    uni_d   = step[13:10];
                    done_d  = 1'b1;
                end else begin
                    it_d = it_q + 4'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Free-running scan: hold each digit DIV cycles, cycle 01 -> 10 -> 11 -> 01.
    always_comb begin
        presc_d   = presc_q;
        mostrar_d = mostrar_q;
        if (presc_q == PRESC_LAST) begin
            presc_d   = '0;
            mostrar_d = (mostrar_q == 2'b11) ? 2'b01 : mostrar_q + 2'b01;
        end else begin
            presc_d = presc_q + PW'(1);
        end
    end

    // Digit mux follows the displayed BCD immediately, even mid-dwell.
    always_comb begin
        digito = hun_q;
        case (mostrar_q)
            2'b01:   digito = hun_q;
            2'b10:   digito = ten_q;
            2'b11:   digito = uni_q;
            default: digito = hun_q;
        endcase
    end

    assign busy    = (state_q == CONV);
    assign done    = done_q;
    assign mostrar = mostrar_q;

endmodule

// File: tb/tb_display_scan_ctrl.sv
// Self-checking bench for display_scan_ctrl: two instances (DIV=4, DIV=3)
// share one stimulus stream and are compared each cycle with a decimal model.
module tb_display_scan_ctrl;

    localparam int DIV_A = 4;
    localparam int DIV_B = 3;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       load = 1'b0;
    logic [9:0] value = '0;
    logic       busy_a, done_a, busy_b, done_b;
    logic [1:0] mos_a, mos_b;
    logic [3:0] dig_a, dig_b;

    int n_cmp = 0;
    int n_bad = 0;

    // Behavioural model: displayed value as a plain integer, a pending
    // conversion with a countdown, and edges elapsed since reset release.
    int m_cyc  = 0;
    int m_disp = 0;
    bit m_pend = 0;
    int m_pval = 0;
    int m_left = 0;
    bit m_done = 0;
    int done_cnt = 0;

    display_scan_ctrl #(.DIV(DIV_A)) dut_a (
        .clk(clk), .rst(rst), .value(value), .load(load),
        .busy(busy_a), .done(done_a), .mostrar(mos_a), .digito(dig_a)
    );

    display_scan_ctrl #(.DIV(DIV_B)) dut_b (
        .clk(clk), .rst(rst), .value(value), .load(load),
        .busy(busy_b), .done(done_b), .mostrar(mos_b), .digito(dig_b)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int exp_mos(input int cyc, input int div);
        return 1 + (cyc / div) % 3;
    endfunction

    function automatic int digit_of(input int v, input int sel);
        if (sel == 1) return v / 100;
        if (sel == 2) return (v / 10) % 10;
        return v % 10;
    endfunction

    // Model update on each edge, then compare both DUTs just after it.
    initial begin
        forever begin
            @(posedge clk);
            if (rst) begin
                m_cyc = 0; m_disp = 0; m_pend = 0; m_left = 0; m_done = 0;
            end else begin
                m_done = 0;
                if (m_pend) begin
                    m_left--;
                    if (m_left == 0) begin
                        m_disp = m_pval;
                        m_pend = 0;
                        m_done = 1;
                    end
                end else if (load) begin
                    m_pend = 1;
                    m_pval = (int'(value) > 999) ? 999 : int'(value);
                    m_left = 10;
                end
                m_cyc++;
            end
            #1;
            chk("busy_a", busy_a, m_pend);
            chk("done_a", done_a, m_done);
            chk("mostrar_a", mos_a, exp_mos(m_cyc, DIV_A));
            chk("digito_a", dig_a, digit_of(m_disp, exp_mos(m_cyc, DIV_A)));
            chk("busy_b", busy_b, m_pend);
            chk("done_b", done_b, m_done);
            chk("mostrar_b", mos_b, exp_mos(m_cyc, DIV_B));
            chk("digito_b", dig_b, digit_of(m_disp, exp_mos(m_cyc, DIV_B)));
            if (done_a) done_cnt++;
        end
    end

    // Assumes we are at a falling edge; the following rising edge is E0.
    task automatic do_load(input int v);
        value = 10'(v);
        load  = 1'b1;
        @(negedge clk);
        load  = 1'b0;
    endtask

    task automatic wait_idle();
        int k = 0;
        while (busy_a && k < 40) begin
            @(negedge clk);
            k++;
        end
        chk("idle_timeout", busy_a, 0);
    endtask

    // Walk one full frame of instance A and pin each digit to a literal.
    task automatic check_digits(input int h, input int t, input int u);
        for (int i = 0; i < 3 * DIV_A; i++) begin
            @(negedge clk);
            case (mos_a)
                2'b01:   chk("lit_hundreds", dig_a, h);
                2'b10:   chk("lit_tens", dig_a, t);
                default: chk("lit_units", dig_a, u);
            endcase
        end
    endtask

    initial begin
        int d0;
        int k;
        repeat (3) @(negedge clk);
        chk("rst_mostrar", mos_a, 1);
        chk("rst_digito", dig_a, 0);
        chk("rst_busy", busy_a, 0);
        chk("rst_done", done_a, 0);
        rst = 1'b0;

        // Scan stepping on DIV=4, plus instance B after 12 edges.
        repeat (4) @(negedge clk);
        chk("scan_step1", mos_a, 2);
        repeat (4) @(negedge clk);
        chk("scan_step2", mos_a, 3);
        repeat (4) @(negedge clk);
        chk("scan_wrap", mos_a, 1);
        chk("scan_b_12", mos_b, 2);

        // 345: busy for ten edges, single done pulse, digits 3/4/5.
        d0 = done_cnt;
        do_load(345);
        repeat (9) @(negedge clk);
        chk("busy_at_E9", busy_a, 1);
        @(negedge clk);
        chk("busy_after_E10", busy_a, 0);
        chk("done_after_E10", done_a, 1);
        @(negedge clk);
        chk("done_after_E11", done_a, 0);
        check_digits(3, 4, 5);
        chk("done_once", done_cnt - d0, 1);

        // Boundary values including saturation.
        do_load(0);    wait_idle(); check_digits(0, 0, 0);
        do_load(999);  wait_idle(); check_digits(9, 9, 9);
        do_load(1023); wait_idle(); check_digits(9, 9, 9);
        chk("model_sat", m_disp, 999);

        // Loads at E3 and E10 dropped; load at E11 accepted.
        value = 10'd123; load = 1'b1;
        @(negedge clk);                 // E0
        load = 1'b0;
        repeat (2) @(negedge clk);      // E1, E2
        value = 10'd456; load = 1'b1;
        @(negedge clk);                 // E3
        load = 1'b0;
        repeat (6) @(negedge clk);      // E4..E9
        load = 1'b1;
        @(negedge clk);                 // E10
        chk("busy_E10", busy_a, 0);
        chk("model_123", m_disp, 123);
        @(negedge clk);                 // E11
        load = 1'b0;
        chk("accept_E11", busy_a, 1);
        repeat (9) @(negedge clk);      // E12..E20
        chk("busy_E20", busy_a, 1);
        chk("model_still_123", m_disp, 123);
        @(negedge clk);                 // E21
        chk("busy_E21", busy_a, 0);
        chk("model_456", m_disp, 456);
        check_digits(4, 5, 6);

        // Reset in the middle of converting 678 over a display of 111.
        do_load(111); wait_idle(); check_digits(1, 1, 1);
        d0 = done_cnt;
        do_load(678);
        repeat (4) @(negedge clk);      // E1..E4
        rst = 1'b1;
        #1;
        chk("async_rst_busy", busy_a, 0);
        chk("async_rst_digito", dig_a, 0);
        chk("async_rst_mostrar", mos_a, 1);
        @(negedge clk);                 // E5 under reset
        rst = 1'b0;
        repeat (15) @(negedge clk);
        chk("no_done_after_rst", done_cnt - d0, 0);
        chk("model_rst_disp", m_disp, 0);
        check_digits(0, 0, 0);

        // Instance B (DIV=3): conversion finishing in the middle of the tens dwell.
        k = 0;
        while ((m_cyc % 9) != 2 && k < 20) begin
            @(negedge clk);
            k++;
        end
        chk("align_timeout", m_cyc % 9, 2);
        do_load(258);                   // E0
        repeat (9) @(negedge clk);      // E1..E9
        chk("b_mos_before", mos_b, 2);
        chk("b_tens_old", dig_b, 0);
        @(negedge clk);                 // E10
        chk("b_mos_E10", mos_b, 2);
        chk("b_tens_new", dig_b, 5);
        @(negedge clk);
        chk("b_mos_E11", mos_b, 2);
        @(negedge clk);
        chk("b_mos_step", mos_b, 3);
        chk("b_units_new", dig_b, 8);

        // Randomized traffic with occasional resets and saturated values.
        for (int i = 0; i < 500; i++) begin
            rst  = ($urandom % 150) == 0;
            load = ($urandom % 3) == 0;
            if (($urandom % 6) == 0) value = 10'(1000 + $urandom % 24);
            else                     value = 10'($urandom % 1024);
            @(negedge clk);
        end
        rst = 1'b0;
        load = 1'b0;
        repeat (20) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/display_scan_ctrl.md
# display_scan_ctrl

Sequencing controller for the three-digit 7-segment display decoder in the ultrasonic range-finder. It accepts a binary value (0–999, saturating) with a load strobe and converts it to BCD by sequential double-dabble. It then time-multiplexes the three BCD digits onto the decoder's `mostrar`/`digito` inputs at a parameterised refresh rate. It sits between the distance-measurement logic and the display decoder.

## Interface
- `DIV`, 50000: clock cycles each digit is held before the scan advances; must be ≥ 2.
- `clk`  in  1  system clock; all state changes on its rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `value`  in  10  binary value to display; sampled only when `load` is accepted.
- `load`  in  1  single-cycle request to convert `value`; accepted only when `busy` = 0.
- `busy`  out  1  conversion in progress; `load` is ignored while high.
- `done`  out  1  one-cycle pulse after the new digits become visible.
- `mostrar`  out  2  digit select to the decoder: 01 hundreds (leftmost), 10 tens, 11 units.
- `digito`  out  4  BCD digit for the currently selected position.

## Operation
- Reset state:
  - `mostrar` = 01.
  - Prescaler = 0.
  - Displayed BCD = 0,0,0, so `digito` = 0.
  - `busy` = 0.
  - `done` = 0.
  - Shift register cleared.
- FSM states are IDLE and CONV.
  - IDLE → CONV when `load` = 1 at a clock edge.
  - CONV → IDLE after exactly 10 shift cycles.
- Load capture:
  - The captured operand is min(`value`, 999). Any value in 1000–1023 displays as 9,9,9.
  - The shift register is 22 bits: 12 bits of BCD (cleared on load) and 10 bits of binary (the saturated operand).
- CONV iteration (one per cycle):
  - Add 3 to each BCD nibble that is ≥ 5.
  - Then shift the whole 22-bit register left by 1.
  - Use a 4-bit iteration counter running 0..9.
- Completion:
  - On the 10th shift edge, the upper 12 bits are copied into the displayed-BCD registers (hundreds, tens, units).
  - On that same edge `busy` clears and `done` is set for one cycle.
- `load` while `busy` = 1 is dropped, not queued. The displayed digits are unaffected until the current conversion completes.
- Scan prescaler:
  - Counts 0..DIV−1.
  - At the terminal count it wraps to 0, and `mostrar` advances 01 → 10 → 11 → 01.
  - Value 00 is never produced.
- `digito` is combinational from the registered `mostrar` and displayed BCD: 01 → hundreds, 10 → tens, 11 → units.
  - A displayed-BCD update mid-dwell changes `digito` immediately, without waiting for a scan step.
- The scan runs continuously and independently of conversion. Conversion never stalls or resets the prescaler.
- Reset asserted mid-conversion:
  - Aborts the conversion immediately.
  - All registers return to their reset values, so the previous digits are lost and 0,0,0 is shown.

## Timing
- Conversion timing, for `load` sampled at edge E0:
  - `busy` = 1 from after E0 until after E10.
  - New digits are visible on `digito` after E10.
  - `done` = 1 for the single cycle between E10 and E11.
- Load acceptance:
  - A `load` at E10 is ignored, because `busy` is still 1 at that edge.
  - The earliest next accepted `load` is at E11, giving a throughput of one conversion per 11 cycles.
- Digit scan:
  - Each `mostrar` value is held exactly DIV cycles; the full frame is 3·DIV cycles.
  - With DIV = 50000 at 50 MHz: 1 ms per digit, 333 Hz frame.
- After reset release, the first `mostrar` transition occurs DIV edges later.
- Arithmetic: each nibble's add-3 is a 4-bit add with no carry out (result ≤ 12). The saturation compare is done on the 10-bit input.

## Test plan
- Reset with DIV = 4 → `mostrar` = 01, `digito` = 0, `busy` = 0, `done` = 0. `mostrar` steps 01 → 10 → 11 → 01 every 4 cycles.
- `load` with `value` = 345 → `busy` high for 10 cycles. After completion, `digito` reads 3/4/5 for `mostrar` = 01/10/11. `done` pulses exactly once.
- `value` = 0, then 999, then 1023 (each after `busy` falls) → digits 0,0,0, then 9,9,9, then 9,9,9 (saturated).
- `load` with `value` = 123, then `load` with `value` = 456 at cycles E3 and E10 → both later loads ignored. Display shows 1,2,3. `load` with `value` = 456 at E11 is accepted and shows 4,5,6 after E21.
- `rst` pulsed at cycle E5 of a conversion of 678, with previous display 111 → after reset, digits 0,0,0, `busy` = 0, no `done` pulse. The scan restarts at `mostrar` = 01.
- DIV = 3 with a conversion completing mid-dwell of `mostrar` = 10 → `digito` switches to the new tens digit in the same dwell. Scan step timing is unchanged.
